// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline front-end hazard controller.
//   state_t      : sequencer states (2'd3 is unused and decodes as RUN)
//   ctrl_t       : bundle of the four pipeline-register control strobes
//   CTRL_*       : the five control patterns the sequencer can drive
//   NOP_INSTR    : instruction word loaded into IF/ID on a flush
//   PERF_CNT_W   : width of the performance counters
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   localparam logic [7:0] NOP_INSTR  = 8'h00;
   localparam int         PERF_CNT_W = 16;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_bubble;
   } ctrl_t;

   // Reset: nothing advances, both pipeline registers are forced to NOP.
   localparam ctrl_t CTRL_RESET = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
   // Memory freeze: every register holds its contents.
   localparam ctrl_t CTRL_HOLD  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
   // Normal flow.
   localparam ctrl_t CTRL_RUN   = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
   // Load-use stall: PC and IF/ID hold, a bubble enters EX.
   localparam ctrl_t CTRL_STALL = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
   // Taken jump: fetch the target, squash the wrong-path instruction in IF/ID.
   localparam ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1};

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
// -----------------------------------------------------------------------------
// haz_sat_cnt
// Saturating up-counter used for the hazard performance counters. It sticks
// at all-ones instead of wrapping so a long run never reports a small value.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset, clears the count
//   inc   in   increment enable for this cycle
//   count out  current count (PERF_CNT_W bits)
// -----------------------------------------------------------------------------
module haz_sat_cnt
   import pipe_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   output logic [PERF_CNT_W-1:0] count
);

   // NOTE: clocked state is written with <= so every flop samples the values
   // from before the edge; blocking assignments here would create ordering races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule : haz_sat_cnt

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Front-end sequencer for the 8-bit in-order pipeline. Generates the PC write
// enable, IF/ID write enable, IF/ID flush and ID/EX bubble strobes from three
// conditions, in priority order:
//   1. mem_busy    : freeze the whole pipe (all strobes low, state held)
//   2. jump_taken  : flush the wrong-path fetch for FLUSH_CYCLES cycles
//   3. load-use    : stall PC/IF/ID and bubble EX for LU_STALL_CYCLES cycles
// Strobes are combinational from state, counter and inputs (same-cycle).
//
// Build option: define HAZ_PERF_CNT_EN to implement stall_cnt / flush_cnt.
// Without it there are no counter flops and both ports read 16'h0000.
//
// Parameters:
//   REG_AW          register-file address width
//   LU_STALL_CYCLES stall cycles per load-use hazard (1..7)
//   FLUSH_CYCLES    flush cycles per taken jump (1..7)
//   CNT_W           sequencing counter width, holds max of the two above
// Ports:
//   clk, rst                    clock (rising) / async active-low reset
//   id_rs, id_rt                source registers of the instruction in ID
//   id_uses_rs, id_uses_rt      ID instruction actually reads that source
//   ex_rd, ex_mem_read          destination / is-load of the instruction in EX
//   jump_taken                  jump or branch resolved taken this cycle
//   mem_busy                    memory not ready, freeze the pipe
//   pc_we, if_id_we             write enables of PC and IF/ID
//   if_id_flush                 load IF/ID with NOP (PC field 0)
//   id_ex_bubble                load ID/EX with NOP
//   stall_cnt, flush_cnt        saturating stall-cycle / flush-event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW          = 2,
   parameter int LU_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES    = 1,
   parameter int CNT_W           = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_AW-1:0]     id_rs,
   input  logic [REG_AW-1:0]     id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_AW-1:0]     ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  jump_taken,
   input  logic                  mem_busy,
   output logic                  pc_we,
   output logic                  if_id_we,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LU_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   ctrl_t            ctrl;
   logic             lu_hazard;
   logic             flush_event;

   // Register 0 is an ordinary register here; it gets no special treatment.
   assign lu_hazard = ex_mem_read &
                      ((id_uses_rs & (id_rs == ex_rd)) |
                       (id_uses_rt & (id_rt == ex_rd)));

   // A flush event is a taken jump that is actually acted on this cycle.
   assign flush_event = rst & ~mem_busy & jump_taken;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the if/case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ctrl      = CTRL_RUN;

      if (!rst) begin
         ctrl = CTRL_RESET;
      end else if (mem_busy) begin
         ctrl = CTRL_HOLD;
      end else if (jump_taken) begin
         // Jump wins over any stall in progress or pending hazard.
         ctrl = CTRL_FLUSH;
         if (FLUSH_CYCLES > 1) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = FLUSH_RELOAD;
         end else begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      end else begin
         case (state)
            ST_LU_STALL: begin
               // The first bubble already moved the load out of EX, so the
               // counter, not lu_hazard, keeps the stall going.
               ctrl = CTRL_STALL;
               if (cnt <= CNT_W'(1)) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt   = cnt - 1'b1;
               end
            end
            ST_FLUSH: begin
               ctrl = CTRL_FLUSH;
               if (cnt <= CNT_W'(1)) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt   = cnt - 1'b1;
               end
            end
            default: begin
               // ST_RUN, and the unused encoding which recovers to RUN.
               state_nxt = ST_RUN;
               if (lu_hazard) begin
                  ctrl = CTRL_STALL;
                  if (LU_STALL_CYCLES > 1) begin
                     state_nxt = ST_LU_STALL;
                     cnt_nxt   = LU_RELOAD;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign pc_we        = ctrl.pc_we;
   assign if_id_we     = ctrl.if_id_we;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_bubble = ctrl.id_ex_bubble;

`ifdef HAZ_PERF_CNT_EN
   // A stall cycle is a bubble that is not part of a flush.
   logic stall_event;
   assign stall_event = rst & ctrl.id_ex_bubble & ~ctrl.if_id_flush;

   haz_sat_cnt u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_event),
      .count (stall_cnt)
   );

   haz_sat_cnt u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_event),
      .count (flush_cnt)
   );
`else
   logic unused_flush_event;
   assign unused_flush_event = flush_event;
   assign stall_cnt          = '0;
   assign flush_cnt          = '0;
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Drives two controller instances from the same inputs:
//   dut 0 : LU_STALL_CYCLES=1, FLUSH_CYCLES=1
//   dut 1 : LU_STALL_CYCLES=3, FLUSH_CYCLES=2
// The reference model tracks "stall cycles still owed" and "flush cycles still
// owed" per instance and derives the expected strobes from the priority rules.
// Counter expectations follow HAZ_PERF_CNT_EN (zero when it is undefined).
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] id_rs, id_rt, ex_rd;
   logic       id_uses_rs, id_uses_rt, ex_mem_read, jump_taken, mem_busy;

   logic [1:0]  pc_we, if_id_we, if_id_flush, id_ex_bubble;
   logic [15:0] stall_cnt [2];
   logic [15:0] flush_cnt [2];

   int n_cmp = 0;
   int n_bad = 0;

   // Model state per instance.
   int lu_len    [2] = '{1, 3};
   int fl_len    [2] = '{1, 2};
   int stall_left[2];
   int flush_left[2];
   int m_stall   [2];
   int m_flush   [2];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(2), .LU_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .jump_taken(jump_taken), .mem_busy(mem_busy),
      .pc_we(pc_we[0]), .if_id_we(if_id_we[0]),
      .if_id_flush(if_id_flush[0]), .id_ex_bubble(id_ex_bubble[0]),
      .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
   );

   pipe_hazard_ctrl #(.REG_AW(2), .LU_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .jump_taken(jump_taken), .mem_busy(mem_busy),
      .pc_we(pc_we[1]), .if_id_we(if_id_we[1]),
      .if_id_flush(if_id_flush[1]), .id_ex_bubble(id_ex_bubble[1]),
      .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int exp_cnt(input int v);
`ifdef HAZ_PERF_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   // Apply one cycle of inputs at the falling edge, then check both instances
   // and advance the model past the coming rising edge.
   task automatic cyc(input string tag, input logic r, input logic busy, input logic jmp,
                      input logic mr, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [1:0] rt, input logic urs, input logic urt);
      logic       haz;
      logic [3:0] exp;
      @(negedge clk);
      rst = r; mem_busy = busy; jump_taken = jmp; ex_mem_read = mr;
      ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      #1;
      haz = mr && ((urs && rs == rd) || (urt && rt == rd));
      for (int k = 0; k < 2; k++) begin
         if (!r) begin
            stall_left[k] = 0; flush_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            exp = 4'b0011;
         end else if (busy)              exp = 4'b0000;
         else if (jmp)                   exp = 4'b1111;
         else if (stall_left[k] > 0)     exp = 4'b0001;
         else if (flush_left[k] > 0)     exp = 4'b1111;
         else if (haz)                   exp = 4'b0001;
         else                            exp = 4'b1100;

         check($sformatf("%s/d%0d/ctrl", tag, k),
               {28'd0, pc_we[k], if_id_we[k], if_id_flush[k], id_ex_bubble[k]}, {28'd0, exp});
         check($sformatf("%s/d%0d/stall_cnt", tag, k), {16'd0, stall_cnt[k]}, exp_cnt(m_stall[k]));
         check($sformatf("%s/d%0d/flush_cnt", tag, k), {16'd0, flush_cnt[k]}, exp_cnt(m_flush[k]));

         if (r && !busy) begin
            if (jmp) begin
               flush_left[k] = fl_len[k] - 1;
               stall_left[k] = 0;
               if (m_flush[k] < 65535) m_flush[k]++;
            end else if (stall_left[k] > 0) stall_left[k]--;
            else if (flush_left[k] > 0)     flush_left[k]--;
            else if (haz)                   stall_left[k] = lu_len[k] - 1;
            if (exp == 4'b0001 && m_stall[k] < 65535) m_stall[k]++;
         end
      end
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0; mem_busy = 0; jump_taken = 0; ex_mem_read = 0;
      ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      for (int k = 0; k < 2; k++) begin
         stall_left[k] = 0; flush_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end

      // Reset held three cycles.
      for (int i = 0; i < 3; i++) cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("reset/flush", {31'd0, if_id_flush[0]}, 32'd1);
      check("reset/pc_we", {31'd0, pc_we[1]}, 32'd0);

      // First cycle after release runs normally.
      cyc("release", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("release/pc_we", {30'd0, pc_we}, 32'd3);
      check("release/bubble", {30'd0, id_ex_bubble}, 32'd0);
      idle("idle", 1);

      // Load-use on rs: dut0 stalls one cycle, dut1 three.
      cyc("lu_rs", 1, 0, 0, 1, 2, 2, 0, 1, 0);
      check("lu_rs/stall", {30'd0, pc_we}, 32'd0);
      cyc("lu_after1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("lu_after1/pc_we", {30'd0, pc_we}, 32'd1);
      idle("lu_tail", 3);
`ifdef HAZ_PERF_CNT_EN
      check("lu/stall_cnt0", {16'd0, stall_cnt[0]}, 32'd1);
      check("lu/stall_cnt1", {16'd0, stall_cnt[1]}, 32'd3);
`endif

      // No false hazards.
      cyc("rt_unused", 1, 0, 0, 1, 2, 0, 2, 0, 0);
      check("rt_unused/pc_we", {30'd0, pc_we}, 32'd3);
      cyc("no_load", 1, 0, 0, 0, 2, 2, 2, 1, 1);
      cyc("r0_match", 1, 0, 0, 1, 0, 0, 3, 1, 0);
      idle("r0_tail", 3);

      // Jump and hazard in the same cycle: flush path wins.
      cyc("jmp_haz", 1, 0, 1, 1, 1, 1, 1, 1, 1);
      check("jmp_haz/flush", {30'd0, if_id_flush}, 32'd3);
      cyc("jmp_haz2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("jmp_haz2/flush", {30'd0, if_id_flush}, 32'd2);
      idle("jmp_tail", 2);

      // Jump during a multi-cycle stall aborts the stall.
      cyc("lu_then_jmp", 1, 0, 0, 1, 3, 3, 0, 1, 0);
      cyc("jmp_in_stall", 1, 0, 1, 0, 0, 0, 0, 0, 0);
      idle("abort_tail", 3);

      // Freeze during LU_STALL with two stall cycles still owed on dut1.
      cyc("frz_haz", 1, 0, 0, 1, 1, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) cyc("frz_busy", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("frz_rel1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("frz_rel1/bubble", {30'd0, id_ex_bubble}, 32'd2);
      idle("frz_tail", 3);

      // Freeze with a held jump, then a new jump while flushing.
      cyc("busy_jmp", 1, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc("busy_jmp2", 1, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("reload_jmp", 1, 0, 1, 0, 0, 0, 0, 0, 0);
      idle("reload_tail", 3);

      // Reset mid-stall and mid-flush.
      cyc("rs_stall", 1, 0, 0, 1, 2, 2, 0, 1, 0);
      cyc("rs_assert", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("rs_release", 2);
      cyc("rf_jmp", 1, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("rf_assert", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("rf_release", 2);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         cyc("rand", 1,
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 60,
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

`ifdef HAZ_PERF_CNT_EN
      // Continuous stall long enough to saturate the stall counter.
      for (int i = 0; i < 65540; i++) cyc("sat", 1, 0, 0, 1, 1, 1, 0, 1, 0);
      check("sat/stall_cnt0", {16'd0, stall_cnt[0]}, 32'h0000_FFFF);
      check("sat/stall_cnt1", {16'd0, stall_cnt[1]}, 32'h0000_FFFF);
      cyc("sat_hold", 1, 0, 0, 1, 1, 1, 0, 1, 0);
      check("sat_hold/stall_cnt0", {16'd0, stall_cnt[0]}, 32'h0000_FFFF);
`else
      cyc("nocnt", 1, 0, 1, 0, 0, 0, 0, 0, 0);
      check("nocnt/flush_cnt0", {16'd0, flush_cnt[0]}, 32'd0);
      check("nocnt/stall_cnt1", {16'd0, stall_cnt[1]}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl
